// File: rtl/calc_sequencer.sv
// calc_sequencer: command sequencer driving a stack/queue Memory block through push/pop pulses.
// Define CALC_MUL_EN to enable opcode 8 (MUL); otherwise it is rejected as illegal.
module calc_sequencer #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             mode_sel,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_data,
   output logic [1:0]       rsp_err,
   output logic [5:0]       depth,
   output logic             mem_push,
   output logic             mem_pop,
   output logic             mem_sel,
   output logic             mem_clr_n,
   output logic [WIDTH-1:0] mem_in,
   input  logic [WIDTH-1:0] mem_out,
   input  logic             mem_empty,
   input  logic             mem_full
);
   typedef enum logic [3:0] {IDLE, PUSH, POPA, WAITA, POPB, WAITB, EXEC, PUSHR, CLR, RESP} state_t;
   state_t state;
   logic [3:0] op;
   logic [WIDTH-1:0] a, b, res, alu, prod;
   logic [1:0] err, cnt;
   logic legal;
`ifdef CALC_MUL_EN
   assign prod  = b * a;
   assign legal = cmd_op <= 4'd8;
`else
   assign prod  = '0;
   assign legal = cmd_op <= 4'd7;
`endif
   assign cmd_ready = state == IDLE;
   assign alu = op == 4'd2 ? b + a :
                op == 4'd3 ? b - a :
                op == 4'd4 ? b & a :
                op == 4'd5 ? b | a :
                op == 4'd6 ? b ^ a : prod;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         op        <= '0;
         a         <= '0;
         b         <= '0;
         res       <= '0;
         err       <= '0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= '0;
         depth     <= '0;
         mem_push  <= 1'b0;
         mem_pop   <= 1'b0;
         mem_sel   <= 1'b0;
         mem_clr_n <= 1'b0;
         mem_in    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         mem_push  <= 1'b0;
         mem_pop   <= 1'b0;
         case (state)
            IDLE: begin
               mem_clr_n <= 1'b1;
               if (cmd_valid) begin
                  op    <= cmd_op;
                  res   <= '0;
                  err   <= 2'd0;
                  state <= RESP;
                  if (cmd_op == 4'd0 && depth == 6'(DEPTH)) err <= 2'd1;
                  else if (cmd_op == 4'd0) begin
                     state    <= PUSH;
                     mem_push <= 1'b1;
                     mem_in   <= cmd_data;
                  end else if (cmd_op == 4'd7) begin
                     state     <= CLR;
                     cnt       <= 2'd1;
                     mem_clr_n <= 1'b0;
                     mem_sel   <= mode_sel;
                  end else if (!legal) err <= 2'd3;
                  else if (depth == 6'd0 || (cmd_op != 4'd1 && depth == 6'd1)) err <= 2'd2;
                  else begin
                     state   <= POPA;
                     mem_pop <= 1'b1;
                  end
               end
            end
            PUSH: begin
               depth <= depth + 6'd1;
               state <= RESP;
            end
            POPA: begin
               depth <= depth - 6'd1;
               cnt   <= 2'(RD_LAT - 1);
               state <= WAITA;
            end
            WAITA: if (cnt != 2'd0) cnt <= cnt - 2'd1;
            else begin
               a       <= mem_out;
               res     <= mem_out;
               state   <= op == 4'd1 ? RESP : POPB;
               mem_pop <= op != 4'd1;
            end
            POPB: begin
               depth <= depth - 6'd1;
               cnt   <= 2'(RD_LAT - 1);
               state <= WAITB;
            end
            WAITB: if (cnt != 2'd0) cnt <= cnt - 2'd1;
            else begin
               b     <= mem_out;
               state <= EXEC;
            end
            EXEC: begin
               res      <= alu;
               mem_in   <= alu;
               mem_push <= 1'b1;
               state    <= PUSHR;
            end
            PUSHR: begin
               depth <= depth + 6'd1;
               state <= RESP;
            end
            CLR: if (cnt != 2'd0) cnt <= cnt - 2'd1;
            else begin
               depth     <= '0;
               mem_clr_n <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b1;
               rsp_data  <= res;
               rsp_err   <= err;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifndef SYNTHESIS
   // the sequencer's own count must agree with the Memory flags whenever it is idle
   always @(posedge clk)
      if (rst && mem_clr_n && state == IDLE)
         assert ((depth == 6'd0) == mem_empty && (depth == 6'(DEPTH)) == mem_full)
         else $error("calc_sequencer depth %0d disagrees with memory flags", depth);
`endif
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench with behavioural stack/queue memory and response scoreboard.
module tb_calc_sequencer;
   localparam int W  = 32;
   localparam int RL = 2;
   logic clk = 0, rst = 0, cmd_valid = 0, mode_sel = 0;
   logic [3:0] cmd_op = 0;
   logic [W-1:0] cmd_data = 0;
   logic cmd_ready, rsp_valid, mem_push, mem_pop, mem_sel, mem_clr_n, mem_empty, mem_full;
   logic [W-1:0] rsp_data, mem_in, mem_out;
   logic [1:0] rsp_err;
   logic [5:0] depth;
   int checks = 0, errors = 0, npush = 0, npop = 0, expd = 0;
   logic [33:0] sb [$];
   logic [W-1:0] mm [0:31];
   logic [W-1:0] pipe [0:RL-1];
   int hd = 0, cn = 0;

   calc_sequencer #(.WIDTH(W), .DEPTH(32), .RD_LAT(RL)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .mode_sel(mode_sel), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .depth(depth), .mem_push(mem_push), .mem_pop(mem_pop), .mem_sel(mem_sel),
      .mem_clr_n(mem_clr_n), .mem_in(mem_in), .mem_out(mem_out), .mem_empty(mem_empty),
      .mem_full(mem_full));

   always #5 clk = ~clk;

   assign mem_out   = pipe[RL-1];
   assign mem_empty = cn == 0;
   assign mem_full  = cn == 32;
   always @(posedge clk) begin
      if (!mem_clr_n) begin
         hd <= 0;
         cn <= 0;
      end else if (mem_push) begin
         mm[(hd + cn) % 32] <= mem_in;
         cn <= cn + 1;
      end else if (mem_pop) begin
         pipe[0] <= mem_sel ? mm[hd] : mm[(hd + cn - 1) % 32];
         hd <= mem_sel ? (hd + 1) % 32 : hd;
         cn <= cn - 1;
      end
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
      if (mem_push) npush <= npush + 1;
      if (mem_pop) npop <= npop + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [33:0] e;
      if (rst) begin
         chk("push_pop_excl", {62'd0, mem_push & mem_pop, ~mem_clr_n & (mem_push | mem_pop)}, 64'd0);
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_rsp: observed rsp_valid 1 expected 0");
            end else begin
               e = sb.pop_front();
               chk("rsp_data", rsp_data, e[33:2]);
               chk("rsp_err", rsp_err, e[1:0]);
            end
         end
      end
   end

   task automatic do_cmd(input logic [3:0] op, input logic [W-1:0] d, input logic m,
                         input logic [W-1:0] ed, input logic [1:0] ee, input int el);
      int w, lat;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("cmd_ready", cmd_ready, 1);
      cmd_valid = 1;
      cmd_op = op;
      cmd_data = d;
      mode_sel = m;
      sb.push_back({ed, ee});
      @(posedge clk);
      #1 cmd_valid = 0;
      lat = 0;
      @(negedge clk);
      while (!rsp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("latency_op%0d", op), lat, el);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal;
   end

   initial begin
      logic [W-1:0] x, y, r;
      int np;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_depth", depth, 0);
      chk("rst_mem_push", mem_push, 0);
      chk("rst_mem_pop", mem_pop, 0);
      chk("rst_mem_in", mem_in, 0);
      chk("rst_mem_sel", mem_sel, 0);
      chk("rst_mem_clr_n", mem_clr_n, 0);
      rst = 1;
      @(negedge clk);
      chk("rel_mem_clr_n", mem_clr_n, 1);
      // stack mode arithmetic
      do_cmd(0, 10, 0, 0, 0, 2);
      do_cmd(0, 3, 0, 0, 0, 2);
      do_cmd(3, 0, 0, 7, 0, 5 + 2 * RL);
      chk("depth_after_sub", depth, 1);
      do_cmd(1, 0, 0, 7, 0, 2 + RL);
      chk("depth_after_pop", depth, 0);
      // queue mode
      do_cmd(7, 0, 1, 0, 0, 3);
      chk("mem_sel_queue", mem_sel, 1);
      do_cmd(0, 10, 0, 0, 0, 2);
      do_cmd(0, 3, 0, 0, 0, 2);
      x = 32'd3 - 32'd10;
      do_cmd(3, 0, 0, x, 0, 5 + 2 * RL);
      chk("depth_queue_sub", depth, 1);
      do_cmd(1, 0, 0, x, 0, 2 + RL);
      // fill to capacity
      do_cmd(7, 0, 0, 0, 0, 3);
      chk("mem_sel_stack", mem_sel, 0);
      for (int i = 0; i < 32; i++) do_cmd(0, i, 0, 0, 0, 2);
      chk("depth_full", depth, 32);
      np = npush;
      do_cmd(0, 99, 0, 0, 1, 1);
      chk("overflow_no_push", npush, np);
      chk("depth_overflow", depth, 32);
      do_cmd(1, 0, 0, 31, 0, 2 + RL);
      chk("depth_pop_full", depth, 31);
      do_cmd(7, 0, 0, 0, 0, 3);
      chk("depth_clear", depth, 0);
      // underflow
      do_cmd(1, 0, 0, 0, 2, 1);
      do_cmd(0, 5, 0, 0, 0, 2);
      np = npop;
      do_cmd(2, 0, 0, 0, 2, 1);
      chk("underflow_no_pop", npop, np);
      chk("depth_underflow", depth, 1);
      // illegal ops
      do_cmd(9, 0, 0, 0, 3, 1);
      do_cmd(15, 0, 0, 0, 3, 1);
      expd = 1;
      // random operands through each ALU op
      for (int o = 2; o <= 6; o++) begin
         x = $urandom;
         y = $urandom;
         r = o == 2 ? x + y : o == 3 ? x - y : o == 4 ? x & y : o == 5 ? x | y : x ^ y;
         do_cmd(0, x, 0, 0, 0, 2);
         do_cmd(0, y, 0, 0, 0, 2);
         do_cmd(4'(o), 0, 0, r, 0, 5 + 2 * RL);
         expd++;
         chk($sformatf("depth_op%0d", o), depth, expd);
      end
      do_cmd(0, 6, 0, 0, 0, 2);
      do_cmd(0, 7, 0, 0, 0, 2);
      expd += 2;
`ifdef CALC_MUL_EN
      do_cmd(8, 0, 0, 42, 0, 5 + 2 * RL);
      expd--;
`else
      do_cmd(8, 0, 0, 0, 3, 1);
`endif
      chk("depth_mul", depth, expd);
      // reset while waiting on the second operand
      do_cmd(7, 0, 0, 0, 0, 3);
      do_cmd(0, 1, 0, 0, 0, 2);
      do_cmd(0, 2, 0, 0, 0, 2);
      @(negedge clk);
      cmd_valid = 1;
      cmd_op = 2;
      @(posedge clk);
      #1 cmd_valid = 0;
      repeat (5) @(negedge clk);
      rst = 0;
      #1;
      chk("midrst_depth", depth, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_mem_clr_n", mem_clr_n, 0);
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("midrst_clr_release", mem_clr_n, 1);
      repeat (10) @(negedge clk);
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_depth", depth, 0);
      do_cmd(0, 32'h55, 0, 0, 0, 2);
      do_cmd(1, 0, 0, 32'h55, 0, 2 + RL);
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
